// File: rtl/noc_pkg.sv
// Shared NoC definitions: default widths and the flit pack/extract helpers
// used by both the network interface and the router.
package noc_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_CL_W      = 2;
  localparam int DEF_LO_W      = 2;
  localparam int DEF_FLIT_W    = DEF_DATA_W + DEF_CL_W + DEF_LO_W;
  localparam int DEF_INJ_DEPTH = 4;
  localparam int DEF_EJ_DEPTH  = 4;
  localparam int DEF_CREDITS   = 4;
  localparam int DEF_CNT_W     = 16;

  typedef logic [DEF_FLIT_W-1:0] flit_t;

  // Flit layout, MSB first: {dst_cluster, dst_local, data}
  function automatic flit_t flit_pack(input logic [DEF_CL_W-1:0]   cl,
                                      input logic [DEF_LO_W-1:0]   lo,
                                      input logic [DEF_DATA_W-1:0] data);
    return {cl, lo, data};
  endfunction

  function automatic logic [DEF_CL_W-1:0] flit_cluster(input flit_t f);
    return f[DEF_FLIT_W-1 -: DEF_CL_W];
  endfunction

  function automatic logic [DEF_LO_W-1:0] flit_local(input flit_t f);
    return f[DEF_DATA_W +: DEF_LO_W];
  endfunction

  function automatic logic [DEF_DATA_W-1:0] flit_data(input flit_t f);
    return f[DEF_DATA_W-1:0];
  endfunction

endpackage

// File: rtl/noc_ni_if.sv
// PE-side and router-side handshake bundle of the network interface.
// valid/ready: a transfer happens on a clock edge where both valid and ready are
// high; the source holds valid and its payload stable until that edge, and ready
// never depends combinationally on valid.
interface noc_ni_if #(
    parameter int DATA_W = noc_pkg::DEF_DATA_W,
    parameter int CL_W   = noc_pkg::DEF_CL_W,
    parameter int LO_W   = noc_pkg::DEF_LO_W
);
    localparam int FLIT_W = DATA_W + CL_W + LO_W;

    logic              pe_valid;
    logic              pe_ready;
    logic [CL_W-1:0]   pe_dst_cluster;
    logic [LO_W-1:0]   pe_dst_local;
    logic [DATA_W-1:0] pe_data;
    logic              ej_valid;
    logic              ej_ready;
    logic [DATA_W-1:0] ej_data;
    logic [FLIT_W-1:0] inject;
    logic              inject_valid;
    logic              credit_in;
    logic [FLIT_W-1:0] eject;
    logic              eject_valid;
    logic              credit_out;

    // slave: the network interface itself; master: the PE plus router around it
    modport slave (
        input  pe_valid, pe_dst_cluster, pe_dst_local, pe_data, ej_ready,
               credit_in, eject, eject_valid,
        output pe_ready, ej_valid, ej_data, inject, inject_valid, credit_out
    );

    modport master (
        output pe_valid, pe_dst_cluster, pe_dst_local, pe_data, ej_ready,
               credit_in, eject, eject_valid,
        input  pe_ready, ej_valid, ej_data, inject, inject_valid, credit_out
    );
endinterface

// File: rtl/noc_fifo.sv
// Show-ahead FIFO with an explicit occupancy count so any depth works; a push
// into a full FIFO is accepted when a pop happens in the same cycle.
module noc_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == OCC_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/noc_ni.sv
// Network interface between a PE and the router's local port: credit-checked
// injection, buffered ejection with credit return, statistics and sticky errors.
module noc_ni
    import noc_pkg::*;
#(
    parameter int DATA_W    = noc_pkg::DEF_DATA_W,
    parameter int CL_W      = noc_pkg::DEF_CL_W,
    parameter int LO_W      = noc_pkg::DEF_LO_W,
    parameter int INJ_DEPTH = noc_pkg::DEF_INJ_DEPTH,
    parameter int EJ_DEPTH  = noc_pkg::DEF_EJ_DEPTH,
    parameter int CREDITS   = noc_pkg::DEF_CREDITS,
    parameter int CNT_W     = noc_pkg::DEF_CNT_W,
    localparam int FLIT_W   = DATA_W + CL_W + LO_W,
    localparam int CRED_W   = $clog2(CREDITS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    noc_ni_if.slave           bus,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  tx_count,
    output logic [CNT_W-1:0]  rx_count,
    output logic              err_credit_ovf,
    output logic              err_ej_ovf,
    output logic [CRED_W-1:0] dbg_cred
);
    logic [FLIT_W-1:0] inj_head;
    logic [FLIT_W-1:0] ej_head;
    logic              inj_full, inj_empty;
    logic              ej_full, ej_empty;
    logic              pe_push, send;
    logic              ej_pop, ej_accept;
    logic [CRED_W-1:0] cred;

    assign bus.pe_ready = !inj_full;
    assign pe_push      = bus.pe_valid && !inj_full;
    assign send         = !inj_empty && (cred != '0);

    noc_fifo #(.W(FLIT_W), .DEPTH(INJ_DEPTH)) u_inj_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (pe_push),
        .pop   (send),
        .din   (flit_pack(bus.pe_dst_cluster, bus.pe_dst_local, bus.pe_data)),
        .dout  (inj_head),
        .full  (inj_full),
        .empty (inj_empty)
    );

    assign bus.ej_valid = !ej_empty;
    assign bus.ej_data  = flit_data(ej_head);
    assign ej_pop       = !ej_empty && bus.ej_ready;
    // A full ejection FIFO still takes the flit when the PE drains one the same cycle
    assign ej_accept    = bus.eject_valid && (!ej_full || ej_pop);

    noc_fifo #(.W(FLIT_W), .DEPTH(EJ_DEPTH)) u_ej_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (bus.eject_valid),
        .pop   (ej_pop),
        .din   (bus.eject),
        .dout  (ej_head),
        .full  (ej_full),
        .empty (ej_empty)
    );

    assign dbg_cred = cred;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cred           <= CRED_W'(CREDITS);
            err_credit_ovf <= 1'b0;
        end else begin
            case ({send, bus.credit_in})
                2'b10: cred <= cred - 1'b1;
                2'b01: begin
                    if (cred == CRED_W'(CREDITS)) err_credit_ovf <= 1'b1;
                    else                          cred <= cred + 1'b1;
                end
                default: cred <= cred;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.inject       <= '0;
            bus.inject_valid <= 1'b0;
            bus.credit_out   <= 1'b0;
            err_ej_ovf       <= 1'b0;
        end else begin
            if (send) bus.inject <= inj_head;
            bus.inject_valid <= send;
            bus.credit_out   <= ej_pop;
            if (bus.eject_valid && !ej_accept) err_ej_ovf <= 1'b1;
        end
    end

    // Clear has priority: an event in the clearing cycle is not counted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_count <= '0;
            rx_count <= '0;
        end else if (stat_clr) begin
            tx_count <= '0;
            rx_count <= '0;
        end else begin
            tx_count <= tx_count + CNT_W'(send);
            rx_count <= rx_count + CNT_W'(ej_accept);
        end
    end
endmodule

// File: tb/tb_noc_ni.sv
// Directed bench for noc_ni: injection/credit flow, ejection/credit return,
// counters, sticky error flags and mid-stream reset.
module tb_noc_ni;
  logic        clk;
  logic        rst;
  logic        stat_clr;
  logic [15:0] tx_count;
  logic [15:0] rx_count;
  logic        err_credit_ovf;
  logic        err_ej_ovf;
  logic [2:0]  dbg_cred;

  int n_checks  = 0;
  int n_errors  = 0;
  int sent_cnt  = 0;
  int crout_cnt = 0;
  bit mon_en    = 1'b1;

  logic [19:0] exp_q[$];

  noc_ni_if bus ();

  noc_ni dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .stat_clr       (stat_clr),
    .tx_count       (tx_count),
    .rx_count       (rx_count),
    .err_credit_ovf (err_credit_ovf),
    .err_ej_ovf     (err_ej_ovf),
    .dbg_cred       (dbg_cred)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: injected flits in order, credit_out pulse count
  always @(negedge clk) begin
    if (bus.credit_out) crout_cnt++;
    if (mon_en && bus.inject_valid) begin
      sent_cnt++;
      if (exp_q.size() == 0) check("inj_extra", bus.inject_valid, 1'b0);
      else                   check("inject", bus.inject, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic push_word(input logic [1:0] cl, input logic [1:0] lo, input logic [15:0] d);
    int t;
    t = 0;
    bus.pe_valid       = 1'b1;
    bus.pe_dst_cluster = cl;
    bus.pe_dst_local   = lo;
    bus.pe_data        = d;
    while (!bus.pe_ready && t < 20) begin
      tick();
      t++;
    end
    if (t == 20) check("pe_ready_timeout", bus.pe_ready, 1'b1);
    exp_q.push_back({cl, lo, d});
    tick();
    bus.pe_valid = 1'b0;
  endtask

  task automatic credit_pulse();
    bus.credit_in = 1'b1;
    tick();
    bus.credit_in = 1'b0;
    tick();
    tick();
  endtask

  task automatic eject_flit(input logic [19:0] f);
    bus.eject_valid = 1'b1;
    bus.eject       = f;
    tick();
    bus.eject_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pe_ready"}, bus.pe_ready, 1'b1);
    check({tag, "_ej_valid"}, bus.ej_valid, 1'b0);
    check({tag, "_inject_valid"}, bus.inject_valid, 1'b0);
    check({tag, "_inject"}, bus.inject, 20'h0);
    check({tag, "_credit_out"}, bus.credit_out, 1'b0);
    check({tag, "_tx"}, tx_count, 16'h0);
    check({tag, "_rx"}, rx_count, 16'h0);
    check({tag, "_err_cred"}, err_credit_ovf, 1'b0);
    check({tag, "_err_ej"}, err_ej_ovf, 1'b0);
    check({tag, "_cred"}, dbg_cred, 3'd4);
  endtask

  initial begin
    rst             = 1'b0;
    stat_clr        = 1'b0;
    bus.pe_valid    = 1'b0;
    bus.pe_dst_cluster = '0;
    bus.pe_dst_local   = '0;
    bus.pe_data     = '0;
    bus.ej_ready    = 1'b0;
    bus.credit_in   = 1'b0;
    bus.eject       = '0;
    bus.eject_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b1;
    tick();

    // six words with no returned credit: four leave, two wait
    for (int i = 1; i <= 6; i++) push_word(2'd2, 2'd1, 16'(i));
    repeat (4) tick();
    check("a_sent", sent_cnt, 4);
    check("a_cred0", dbg_cred, 3'd0);
    check("a_tx4", tx_count, 16'd4);
    check("a_inj_idle", bus.inject_valid, 1'b0);
    push_word(2'd2, 2'd1, 16'h0007);
    push_word(2'd2, 2'd1, 16'h0008);
    check("a_full_ready", bus.pe_ready, 1'b0);
    credit_pulse();
    credit_pulse();
    check("a_tx6", tx_count, 16'd6);
    check("a_sent6", sent_cnt, 6);
    check("a_cred_after", dbg_cred, 3'd0);
    credit_pulse();
    credit_pulse();
    check("a_tx8", tx_count, 16'd8);
    check("a_ready_back", bus.pe_ready, 1'b1);

    // cred=2, send and credit_in every cycle
    credit_pulse();
    credit_pulse();
    check("b_cred2", dbg_cred, 3'd2);
    push_word(2'd0, 2'd3, 16'h0020);
    for (int i = 1; i <= 10; i++) begin
      bus.credit_in = 1'b1;
      push_word(2'(i), 2'(3 - i), 16'h0020 + 16'(i));
      check("b_cred_hold", dbg_cred, 3'd2);
    end
    bus.credit_in = 1'b0;
    tick();
    tick();
    check("b_cred1", dbg_cred, 3'd1);
    check("b_sent", sent_cnt, 19);
    check("b_tx19", tx_count, 16'd19);
    check("b_no_ovf", err_credit_ovf, 1'b0);
    check("b_sb_empty", exp_q.size(), 0);

    // credit overflow at full credit
    repeat (3) credit_pulse();
    check("e_cred4", dbg_cred, 3'd4);
    check("e_no_ovf_yet", err_credit_ovf, 1'b0);
    credit_pulse();
    check("e_ovf", err_credit_ovf, 1'b1);
    check("e_cred_sat", dbg_cred, 3'd4);

    // five ejects with PE stalled: fifth dropped
    for (int i = 0; i < 5; i++) eject_flit(20'hCA000 + 20'(i));
    tick();
    check("c_ej_ovf", err_ej_ovf, 1'b1);
    check("c_rx4", rx_count, 16'd4);
    check("c_no_crout", crout_cnt, 0);
    check("c_ej_valid", bus.ej_valid, 1'b1);
    bus.ej_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("c_ej_data", bus.ej_data, 16'hA000 + 16'(i));
      tick();
      check("c_crout_hi", bus.credit_out, 1'b1);
    end
    bus.ej_ready = 1'b0;
    check("c_ej_empty", bus.ej_valid, 1'b0);
    tick();
    check("c_crout_lo", bus.credit_out, 1'b0);
    check("c_crout_cnt", crout_cnt, 4);

    // full ejection FIFO: push and pop in the same cycle
    for (int i = 0; i < 4; i++) eject_flit(20'hCB000 + 20'(i));
    bus.eject_valid = 1'b1;
    bus.eject       = 20'hCB004;
    bus.ej_ready    = 1'b1;
    check("d_head", bus.ej_data, 16'hB000);
    tick();
    bus.eject_valid = 1'b0;
    bus.ej_ready    = 1'b0;
    check("d_crout", bus.credit_out, 1'b1);
    check("d_rx9", rx_count, 16'd9);
    tick();
    check("d_crout_one", bus.credit_out, 1'b0);
    check("d_crout_cnt", crout_cnt, 5);
    bus.ej_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("d_ej_data", bus.ej_data, 16'hB000 + 16'(i));
      tick();
    end
    bus.ej_ready = 1'b0;
    check("d_ej_empty", bus.ej_valid, 1'b0);
    tick();

    // stat_clr wins over a same-cycle eject; flags stay
    stat_clr        = 1'b1;
    bus.eject_valid = 1'b1;
    bus.eject       = 20'hCC000;
    tick();
    stat_clr        = 1'b0;
    bus.eject_valid = 1'b0;
    check("s_tx0", tx_count, 16'd0);
    check("s_rx0", rx_count, 16'd0);
    check("s_err_cred", err_credit_ovf, 1'b1);
    check("s_err_ej", err_ej_ovf, 1'b1);
    check("s_ej_valid", bus.ej_valid, 1'b1);

    // reset in the middle of traffic with three ejection flits buffered
    eject_flit(20'hCC001);
    eject_flit(20'hCC002);
    mon_en             = 1'b0;
    bus.pe_valid       = 1'b1;
    bus.pe_dst_cluster = 2'd1;
    bus.pe_dst_local   = 2'd2;
    bus.pe_data        = 16'h0055;
    tick();
    tick();
    check("f_pre_inj", bus.inject_valid, 1'b1);
    check("f_pre_tx", tx_count, 16'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("f_rst");
    bus.pe_valid = 1'b0;
    #3;
    rst = 1'b1;
    tick();
    check("f_post_cred", dbg_cred, 3'd4);
    check("f_post_ej_valid", bus.ej_valid, 1'b0);
    check("f_post_inj", bus.inject_valid, 1'b0);
    check("f_post_ready", bus.pe_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
